// File: rtl/uart_unit.sv
// 8N1 UART stage with programmable baud divisor and small TX/RX FIFOs.
// Driven by the control unit's rcv/snd/baud command bus; uart_wait stalls the core on rcv.
module uart_unit #(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 434,
    parameter int unsigned TX_DEPTH    = 4,
    parameter int unsigned RX_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  uartc,
    input  logic [31:0] tx_data,
    input  logic [31:0] baud_value,
    input  logic        rx,
    output logic        tx,
    output logic [31:0] rx_data,
    output logic        uart_wait,
    output logic        tx_busy,
    output logic        tx_full,
    output logic        rx_empty,
    output logic        tx_ovf,
    output logic        rx_ovf,
    output logic        frm_err
);

    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);
    localparam int unsigned TX_CW = TX_AW + 1;
    localparam int unsigned RX_CW = RX_AW + 1;

    localparam logic [2:0] CMD_RCV  = 3'b010;
    localparam logic [2:0] CMD_SND  = 3'b011;
    localparam logic [2:0] CMD_BAUD = 3'b100;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    logic cmd_rcv, cmd_snd, cmd_baud;
    assign cmd_rcv  = (uartc == CMD_RCV);
    assign cmd_snd  = (uartc == CMD_SND);
    assign cmd_baud = (uartc == CMD_BAUD);

    logic unused_bits;
    assign unused_bits = ^{tx_data[31:8], baud_value[31:DIV_W]};

    // Baud divisor; values below 4 would leave no room for the mid-bit RX sample.
    logic [DIV_W-1:0] divisor;
    always_ff @(posedge clk) begin
        if (!reset) begin
            divisor <= DIV_W'(DEFAULT_DIV);
        end else if (cmd_baud && (baud_value[DIV_W-1:0] >= DIV_W'(4))) begin
            divisor <= baud_value[DIV_W-1:0];
        end
    end

    // ---------------- TX path ----------------
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr, tx_rd;
    logic [TX_CW-1:0] tx_cnt;
    state_t           tx_state;
    logic [DIV_W-1:0] tx_tcnt, tx_div;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_sh;
    logic             tx_tick, tx_push, tx_pop;

    assign tx_full = (tx_cnt == TX_CW'(TX_DEPTH));
    assign tx_busy = (tx_state != ST_IDLE) || (tx_cnt != '0);
    assign tx_tick = (tx_tcnt == tx_div - DIV_W'(1));
    assign tx_push = cmd_snd && !tx_full;
    assign tx_pop  = (tx_cnt != '0) &&
                     ((tx_state == ST_IDLE) || ((tx_state == ST_STOP) && tx_tick));

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_wr  <= '0;
            tx_rd  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) begin
                tx_mem[tx_wr] <= tx_data[7:0];
                tx_wr         <= tx_wr + TX_AW'(1);
            end
            if (tx_pop) begin
                tx_rd <= tx_rd + TX_AW'(1);
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + TX_CW'(1);
                2'b01:   tx_cnt <= tx_cnt - TX_CW'(1);
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // TX FSM: STOP chains straight into START when another byte is queued.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_state <= ST_IDLE;
            tx       <= 1'b1;
            tx_tcnt  <= '0;
            tx_div   <= DIV_W'(DEFAULT_DIV);
            tx_bit   <= '0;
            tx_sh    <= '0;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    if (tx_pop) begin
                        tx_state <= ST_START;
                        tx       <= 1'b0;
                        tx_tcnt  <= '0;
                        tx_sh    <= tx_mem[tx_rd];
                        tx_div   <= divisor;
                    end
                end
                ST_START: begin
                    if (tx_tick) begin
                        tx_state <= ST_DATA;
                        tx       <= tx_sh[0];
                        tx_tcnt  <= '0;
                        tx_bit   <= '0;
                    end else begin
                        tx_tcnt <= tx_tcnt + DIV_W'(1);
                    end
                end
                ST_DATA: begin
                    if (tx_tick) begin
                        tx_tcnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_state <= ST_STOP;
                            tx       <= 1'b1;
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                            tx_sh  <= tx_sh >> 1;
                            tx     <= tx_sh[1];
                        end
                    end else begin
                        tx_tcnt <= tx_tcnt + DIV_W'(1);
                    end
                end
                ST_STOP: begin
                    if (tx_tick) begin
                        tx_tcnt <= '0;
                        if (tx_pop) begin
                            tx_state <= ST_START;
                            tx       <= 1'b0;
                            tx_sh    <= tx_mem[tx_rd];
                            tx_div   <= divisor;
                        end else begin
                            tx_state <= ST_IDLE;
                        end
                    end else begin
                        tx_tcnt <= tx_tcnt + DIV_W'(1);
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

    // ---------------- RX path ----------------
    logic [1:0]       rx_sync;
    logic             rx_s, rx_prev;
    state_t           rx_state;
    logic [DIV_W-1:0] rx_tcnt, rx_div;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_sh;
    logic             rx_pend, rx_tick, rx_half, frm_set;

    assign rx_s    = rx_sync[1];
    assign rx_tick = (rx_tcnt == rx_div - DIV_W'(1));
    assign rx_half = (rx_tcnt == (rx_div >> 1) - DIV_W'(1));
    assign frm_set = (rx_state == ST_STOP) && rx_tick && !rx_s;

    // RX FSM; the edge detector only re-arms once the line has returned high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= ST_IDLE;
            rx_tcnt  <= '0;
            rx_div   <= DIV_W'(DEFAULT_DIV);
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_pend  <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            rx_prev <= rx_s;
            rx_pend <= 1'b0;
            case (rx_state)
                ST_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_state <= ST_START;
                        rx_tcnt  <= '0;
                        rx_div   <= divisor;
                    end
                end
                ST_START: begin
                    if (rx_half) begin
                        rx_tcnt  <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_tcnt <= rx_tcnt + DIV_W'(1);
                    end
                end
                ST_DATA: begin
                    if (rx_tick) begin
                        rx_tcnt <= '0;
                        rx_sh   <= {rx_s, rx_sh[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state <= ST_STOP;
                        end else begin
                            rx_bit <= rx_bit + 3'd1;
                        end
                    end else begin
                        rx_tcnt <= rx_tcnt + DIV_W'(1);
                    end
                end
                ST_STOP: begin
                    if (rx_tick) begin
                        rx_tcnt  <= '0;
                        rx_state <= ST_IDLE;
                        rx_pend  <= rx_s;
                    end else begin
                        rx_tcnt <= rx_tcnt + DIV_W'(1);
                    end
                end
                default: rx_state <= ST_IDLE;
            endcase
        end
    end

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr, rx_rd;
    logic [RX_CW-1:0] rx_cnt;
    logic             rx_full, rx_push, rx_pop;

    assign rx_full  = (rx_cnt == RX_CW'(RX_DEPTH));
    assign rx_empty = (rx_cnt == '0);
    assign rx_push  = rx_pend && !rx_full;
    assign rx_pop   = cmd_rcv && !rx_empty;
    assign rx_data  = rx_empty ? 32'h0 : 32'(rx_mem[rx_rd]);
    assign uart_wait = cmd_rcv && rx_empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) begin
                rx_mem[rx_wr] <= rx_sh;
                rx_wr         <= rx_wr + RX_AW'(1);
            end
            if (rx_pop) begin
                rx_rd <= rx_rd + RX_AW'(1);
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + RX_CW'(1);
                2'b01:   rx_cnt <= rx_cnt - RX_CW'(1);
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // Sticky error flags; baud clears them, a same-cycle set still wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_ovf  <= 1'b0;
            rx_ovf  <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            if (cmd_baud) begin
                tx_ovf  <= 1'b0;
                rx_ovf  <= 1'b0;
                frm_err <= 1'b0;
            end
            if (cmd_snd && tx_full) tx_ovf <= 1'b1;
            if (rx_pend && rx_full) rx_ovf <= 1'b1;
            if (frm_set)            frm_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_unit.sv
// Directed bench for uart_unit: vector table for command decode, hand sequences for serial timing.
module tb_uart_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  uartc;
    logic [31:0] tx_data;
    logic [31:0] baud_value;
    logic        rx;
    logic        tx;
    logic [31:0] rx_data;
    logic        uart_wait;
    logic        tx_busy, tx_full, rx_empty, tx_ovf, rx_ovf, frm_err;

    int errors = 0;
    int checks = 0;

    uart_unit dut (
        .clk        (clk),
        .reset      (reset),
        .uartc      (uartc),
        .tx_data    (tx_data),
        .baud_value (baud_value),
        .rx         (rx),
        .tx         (tx),
        .rx_data    (rx_data),
        .uart_wait  (uart_wait),
        .tx_busy    (tx_busy),
        .tx_full    (tx_full),
        .rx_empty   (rx_empty),
        .tx_ovf     (tx_ovf),
        .rx_ovf     (rx_ovf),
        .frm_err    (frm_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  c;
        logic [31:0] d;
        logic        w;
        logic        t;
        logic        busy;
        logic        full;
        logic        empty;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] c, input logic [31:0] d);
        uartc      = c;
        tx_data    = d;
        baud_value = d;
        step();
        uartc = 3'b000;
    endtask

    task automatic drive_frame(input logic [7:0] b, input int div, input logic stop);
        rx = 1'b0;
        repeat (div) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (div) @(posedge clk);
            #1;
        end
        rx = stop;
        repeat (div) @(posedge clk);
        #1;
        rx = 1'b1;
    endtask

    // Expected line level k cycles after a frame's start edge.
    function automatic logic exp_line(input logic [7:0] b, input int k, input int div);
        int s;
        s = k / div;
        if (s == 0) return 1'b0;
        if (s >= 9) return 1'b1;
        return b[s-1];
    endfunction

    task automatic measure_start(input int exp_len, input string name);
        int n;
        chk1({name, "_low0"}, tx, 1'b0);
        n = 0;
        while (tx === 1'b0 && n < 1000) begin
            step();
            n++;
        end
        chk({name, "_len"}, 32'(n), 32'(exp_len));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vt [7];
        logic [7:0]  fb [5];
        int          n;

        vt[0] = '{3'b000, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[1] = '{3'b010, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[2] = '{3'b001, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[3] = '{3'b110, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[4] = '{3'b100, 32'h0000_0003, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[5] = '{3'b100, 32'h0000_0008, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[6] = '{3'b011, 32'hFFFF_FFA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44; fb[4] = 8'h55;

        reset = 1'b0; uartc = 3'b000; tx_data = '0; baud_value = '0; rx = 1'b1;
        repeat (3) step();
        reset = 1'b1;
        repeat (100) step();

        // Command decode table from reset state; last entry queues 0xA5 at div 8
        for (int i = 0; i < 7; i++) begin
            uartc = vt[i].c; tx_data = vt[i].d; baud_value = vt[i].d;
            #1;
            chk1($sformatf("v%0d_wait", i), uart_wait, vt[i].w);
            step();
            chk1($sformatf("v%0d_tx", i), tx, vt[i].t);
            chk1($sformatf("v%0d_busy", i), tx_busy, vt[i].busy);
            chk1($sformatf("v%0d_full", i), tx_full, vt[i].full);
            chk1($sformatf("v%0d_empty", i), rx_empty, vt[i].empty);
            chk($sformatf("v%0d_rxd", i), rx_data, 32'h0);
            chk1($sformatf("v%0d_txovf", i), tx_ovf, 1'b0);
            chk1($sformatf("v%0d_rxovf", i), rx_ovf, 1'b0);
            chk1($sformatf("v%0d_frm", i), frm_err, 1'b0);
        end
        uartc = 3'b000;

        // 0xA5 frame, every cycle
        for (int k = 0; k < 80; k++) begin
            step();
            chk1($sformatf("a5_tx_k%0d", k), tx, exp_line(8'hA5, k, 8));
        end
        chk1("a5_busy_end", tx_busy, 1'b1);
        step();
        chk1("a5_busy_fall", tx_busy, 1'b0);
        chk1("a5_tx_idle", tx, 1'b1);

        // Five back-to-back sends; a snd on the full-FIFO pop edge is dropped
        uartc = 3'b011; tx_data = 32'(fb[0]);
        step();
        for (int i = 1; i < 5; i++) begin
            tx_data = 32'(fb[i]);
            step();
            chk1($sformatf("b2b_tx_k%0d", i - 1), tx, exp_line(fb[0], i - 1, 8));
        end
        chk1("b2b_full", tx_full, 1'b1);
        chk1("b2b_ovf_pre", tx_ovf, 1'b0);
        for (int k = 4; k <= 400; k++) begin
            uartc   = (k == 80) ? 3'b011 : 3'b000;
            tx_data = 32'h0000_0066;
            step();
            if (k < 400) chk1($sformatf("b2b_tx_k%0d", k), tx, exp_line(fb[k / 80], k % 80, 8));
            if (k == 79)  chk1("b2b_ovf_k79", tx_ovf, 1'b0);
            if (k == 80)  chk1("b2b_ovf_k80", tx_ovf, 1'b1);
            if (k == 399) chk1("b2b_busy_k399", tx_busy, 1'b1);
        end
        chk1("b2b_busy_fall", tx_busy, 1'b0);
        chk1("b2b_tx_idle", tx, 1'b1);
        send_cmd(3'b100, 32'd8);
        chk1("baud_clr_txovf", tx_ovf, 1'b0);

        // rcv stalls while 0x3C arrives
        fork
            drive_frame(8'h3C, 8, 1'b1);
            begin
                uartc = 3'b010;
                n = 0;
                #1;
                while (uart_wait === 1'b1 && n < 300) begin
                    step();
                    n++;
                end
                chk("rcv_wait_cycles", 32'(n), 32'd80);
                chk1("rcv_wait_low", uart_wait, 1'b0);
                chk("rcv_data", rx_data, 32'h0000_003C);
                step();
                uartc = 3'b000;
                chk1("rcv_empty_after", rx_empty, 1'b1);
                chk("rcv_data_after", rx_data, 32'h0);
            end
        join

        // False start and framing error at div 16
        send_cmd(3'b100, 32'd16);
        rx = 1'b0;
        repeat (4) step();
        rx = 1'b1;
        repeat (60) step();
        chk1("glitch_empty", rx_empty, 1'b1);
        chk1("glitch_frm", frm_err, 1'b0);
        drive_frame(8'h5A, 16, 1'b0);
        repeat (10) step();
        chk1("badstop_empty", rx_empty, 1'b1);
        chk1("badstop_frm", frm_err, 1'b1);
        drive_frame(8'h96, 16, 1'b1);
        repeat (10) step();
        chk1("rearm_empty", rx_empty, 1'b0);
        chk("rearm_data", rx_data, 32'h0000_0096);
        chk1("rearm_frm_sticky", frm_err, 1'b1);
        uartc = 3'b010;
        #1;
        chk1("rearm_pop_wait", uart_wait, 1'b0);
        step();
        uartc = 3'b000;
        send_cmd(3'b100, 32'd8);
        chk1("baud_clr_frm", frm_err, 1'b0);

        // RX overflow: five frames, four slots
        for (int i = 0; i < 4; i++) drive_frame(8'hA1 + 8'(i), 8, 1'b1);
        chk1("rxovf_pre", rx_ovf, 1'b0);
        drive_frame(8'hA5, 8, 1'b1);
        repeat (5) step();
        chk1("rxovf_set", rx_ovf, 1'b1);
        for (int i = 0; i < 4; i++) begin
            uartc = 3'b010;
            #1;
            chk($sformatf("rxovf_pop%0d", i), rx_data, 32'(8'hA1 + 8'(i)));
            step();
        end
        uartc = 3'b000;
        #1;
        chk1("rxovf_drained", rx_empty, 1'b1);

        // Reset mid TX frame with a byte waiting in each FIFO
        drive_frame(8'h77, 8, 1'b1);
        step();
        chk1("pre_rst_rx_full", rx_empty, 1'b0);
        send_cmd(3'b011, 32'h0000_00F0);
        send_cmd(3'b011, 32'h0000_000F);
        repeat (20) step();
        chk1("pre_rst_tx", tx, 1'b0);
        chk1("pre_rst_busy", tx_busy, 1'b1);
        reset = 1'b0;
        step();
        chk1("rst_tx", tx, 1'b1);
        chk1("rst_busy", tx_busy, 1'b0);
        chk1("rst_full", tx_full, 1'b0);
        chk1("rst_empty", rx_empty, 1'b1);
        chk("rst_rxd", rx_data, 32'h0);
        chk1("rst_rxovf", rx_ovf, 1'b0);
        reset = 1'b1;
        step();

        // Divisor back to default, sub-minimum baud ignored
        send_cmd(3'b100, 32'd3);
        send_cmd(3'b011, 32'h0000_0001);
        step();
        measure_start(434, "div_default");

        // Minimum accepted divisor
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        send_cmd(3'b100, 32'd4);
        send_cmd(3'b011, 32'h0000_0001);
        step();
        measure_start(4, "div_min");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
